// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF->ID, regfile read and ID->EX signals for the decode stage.
//   in_*       : instruction handshake from IF (valid/ready, inst, pc)
//   rs*_r_*    : regfile read enables/addresses out, read data back in the same cycle
//   out_*      : decoded entry handshake towards EX
// Modports: slave is the decode stage, master is the surrounding pipeline.
interface id_stage_pipe_if #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_inst;
   logic [XLEN-1:0]   in_pc;
   logic              rs1_r_ena;
   logic [REG_AW-1:0] rs1_r_addr;
   logic              rs2_r_ena;
   logic [REG_AW-1:0] rs2_r_addr;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc;
   logic [2:0]        out_inst_type;
   logic [4:0]        out_opcode;
   logic [2:0]        out_funct3;
   logic [6:0]        out_funct7;
   logic              out_rd_w_ena;
   logic [REG_AW-1:0] out_rd_w_addr;
   logic [XLEN-1:0]   out_imm;
   logic [XLEN-1:0]   out_op1;
   logic [XLEN-1:0]   out_op2;
   logic              out_illegal;
   modport slave (
      input  in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
      output in_ready, rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr,
             out_valid, out_pc, out_inst_type, out_opcode, out_funct3, out_funct7,
             out_rd_w_ena, out_rd_w_addr, out_imm, out_op1, out_op2, out_illegal
   );
   modport master (
      output in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
      input  in_ready, rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr,
             out_valid, out_pc, out_inst_type, out_opcode, out_funct3, out_funct7,
             out_rd_w_ena, out_rd_w_addr, out_imm, out_op1, out_op2, out_illegal
   );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV64I decode stage with a 2-entry skid buffer between IF and EX.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : drop every buffered entry and the instruction presented this cycle
//   bus      : id_stage_pipe_if.slave (IF handshake, regfile read ports, EX handshake)
// Type codes: 0 none, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
// Define ID_ILLEGAL_CHECK_EN to flag unknown opcodes on out_illegal.
module id_stage_pipe #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input logic          clk,
   input logic          rst,
   input logic          flush,
   id_stage_pipe_if.slave bus
);
   localparam logic [2:0] T_NONE = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3,
                          T_B = 3'd4, T_U = 3'd5, T_J = 3'd6;
   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [2:0]        ty;
      logic [4:0]        opc;
      logic [2:0]        f3;
      logic [6:0]        f7;
      logic              we;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic              ill;
   } entry_t;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   logic [31:0] inst;
   logic [4:0]  opc;
   logic [2:0]  ty;
   logic        no_rd;
   logic        uses_rs1;
   logic        uses_rs2;
   entry_t      dec, main_q, skid_q;
   state_t      st, nxt;
   logic        rdy, ld_in, ld_skid, mv;
   assign inst = bus.in_inst;
   assign opc  = inst[6:2];
   // Words whose low bits are not 2'b11 are not 32-bit encodings and decode as type 0.
   always_comb begin
      ty    = T_NONE;
      no_rd = 1'b0;
      case (opc)
         5'b01101, 5'b00101:                   ty = T_U;
         5'b11011:                             ty = T_J;
         5'b11001, 5'b00000, 5'b00100, 5'b00110: ty = T_I;
         5'b00011, 5'b11100: begin
            ty    = T_I;
            no_rd = 1'b1;
         end
         5'b11000:                             ty = T_B;
         5'b01000:                             ty = T_S;
         5'b01100, 5'b01110:                   ty = T_R;
         default:                              ty = T_NONE;
      endcase
      if (inst[1:0] != 2'b11)
         ty = T_NONE;
   end
   assign uses_rs1 = (ty == T_R) || (ty == T_I) || (ty == T_S) || (ty == T_B);
   assign uses_rs2 = (ty == T_R) || (ty == T_S) || (ty == T_B);
   always_comb begin
      dec     = '0;
      dec.pc  = bus.in_pc;
      dec.ty  = ty;
      dec.opc = opc;
      dec.f3  = inst[14:12];
      dec.f7  = inst[31:25];
      dec.rd  = inst[11:7];
      dec.we  = ((ty == T_R) || (ty == T_I) || (ty == T_U) || (ty == T_J)) && !no_rd && (inst[11:7] != '0);
      dec.imm = (ty == T_I) ? {{(XLEN-12){inst[31]}}, inst[31:20]} :
                (ty == T_S) ? {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]} :
                (ty == T_B) ? {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                (ty == T_U) ? {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0} :
                (ty == T_J) ? {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                '0;
      // LUI is the only U-type with a zero base; AUIPC and JAL both add to pc.
      dec.op1 = uses_rs1 ? bus.rs1_data :
                ((ty == T_U) && (opc == 5'b01101)) ? '0 :
                ((ty == T_U) || (ty == T_J)) ? bus.in_pc : '0;
      dec.op2 = uses_rs2 ? bus.rs2_data :
                ((ty == T_I) || (ty == T_U)) ? dec.imm :
                (ty == T_J) ? XLEN'(4) : '0;
`ifdef ID_ILLEGAL_CHECK_EN
      dec.ill = (ty == T_NONE);
`else
      dec.ill = 1'b0;
`endif
   end
   assign bus.rs1_r_ena  = bus.in_valid && !rst && uses_rs1;
   assign bus.rs2_r_ena  = bus.in_valid && !rst && uses_rs2;
   assign bus.rs1_r_addr = inst[19:15];
   assign bus.rs2_r_addr = inst[24:20];
   // ONE with a simultaneous transfer and pop refills main directly, so EX sees no bubble.
   always_comb begin
      nxt     = st;
      ld_in   = 1'b0;
      ld_skid = 1'b0;
      mv      = 1'b0;
      if (flush)
         nxt = EMPTY;
      else
         case (st)
            EMPTY: if (bus.in_valid && rdy) begin
               nxt   = ONE;
               ld_in = 1'b1;
            end
            ONE: if (bus.in_valid && rdy && !bus.out_ready) begin
               nxt     = TWO;
               ld_skid = 1'b1;
            end else if (bus.in_valid && rdy)
               ld_in = 1'b1;
            else if (bus.out_ready)
               nxt = EMPTY;
            TWO: if (bus.out_ready) begin
               nxt = ONE;
               mv  = 1'b1;
            end
            default: nxt = EMPTY;
         endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st     <= EMPTY;
         rdy    <= 1'b1;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         st     <= nxt;
         rdy    <= (nxt != TWO);
         main_q <= ld_in ? dec : mv ? skid_q : main_q;
         skid_q <= ld_skid ? dec : skid_q;
      end
   end
   assign bus.in_ready      = rdy;
   assign bus.out_valid     = (st != EMPTY);
   assign bus.out_pc        = main_q.pc;
   assign bus.out_inst_type = main_q.ty;
   assign bus.out_opcode    = main_q.opc;
   assign bus.out_funct3    = main_q.f3;
   assign bus.out_funct7    = main_q.f7;
   assign bus.out_rd_w_ena  = main_q.we;
   assign bus.out_rd_w_addr = main_q.rd;
   assign bus.out_imm       = main_q.imm;
   assign bus.out_op1       = main_q.op1;
   assign bus.out_op2       = main_q.op2;
   assign bus.out_illegal   = main_q.ill;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors with a scoreboard queue checked by a separate output monitor.
module tb_id_stage_pipe;
   localparam logic [2:0] TN = 3'd0, TI = 3'd2, TS = 3'd3, TU = 3'd5, TJ = 3'd6;
`ifdef ID_ILLEGAL_CHECK_EN
   localparam logic ILL = 1'b1;
`else
   localparam logic ILL = 1'b0;
`endif
   typedef struct packed {
      logic [63:0] pc;
      logic [2:0]  ty;
      logic [4:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        we;
      logic [4:0]  rd;
      logic [63:0] imm;
      logic [63:0] op1;
      logic [63:0] op2;
      logic        ill;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   applied = 0;
   int   miscompares = 0;
   exp_t sb[$];
   exp_t e;
   id_stage_pipe_if #(.XLEN(64), .REG_AW(5)) bus ();
   id_stage_pipe #(.XLEN(64), .REG_AW(5)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
   always #5 clk = ~clk;
   function automatic exp_t mk(input logic [63:0] pc, input logic [2:0] ty, input logic [4:0] opc,
                               input logic [2:0] f3, input logic [6:0] f7, input logic we,
                               input logic [4:0] rd, input logic [63:0] imm, input logic [63:0] op1,
                               input logic [63:0] op2, input logic ill);
      exp_t x;
      x = '{pc, ty, opc, f3, f7, we, rd, imm, op1, op2, ill};
      return x;
   endfunction
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      applied++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            applied++;
            miscompares++;
            $display("FAIL unexpected_entry: got pc %h, required no entry", bus.out_pc);
         end else begin
            e = sb.pop_front();
            check("out_pc", bus.out_pc, e.pc);
            check("out_inst_type", 64'(bus.out_inst_type), 64'(e.ty));
            check("out_opcode", 64'(bus.out_opcode), 64'(e.opc));
            check("out_funct3", 64'(bus.out_funct3), 64'(e.f3));
            check("out_funct7", 64'(bus.out_funct7), 64'(e.f7));
            check("out_rd_w_ena", 64'(bus.out_rd_w_ena), 64'(e.we));
            check("out_rd_w_addr", 64'(bus.out_rd_w_addr), 64'(e.rd));
            check("out_imm", bus.out_imm, e.imm);
            check("out_op1", bus.out_op1, e.op1);
            check("out_op2", bus.out_op2, e.op2);
            check("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
         end
      end
   end
   task automatic present(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] d1,
                          input logic [63:0] d2);
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      bus.rs1_data = d1;
      bus.rs2_data = d2;
   endtask
   task automatic accept(input string name, input logic e1, input logic e2, input bit push,
                         input exp_t x);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         applied++;
         miscompares++;
         $display("FAIL %s_accept_timeout: got in_ready 0, required 1", name);
      end else begin
         check({name, "_rs1_r_ena"}, 64'(bus.rs1_r_ena), 64'(e1));
         check({name, "_rs2_r_ena"}, 64'(bus.rs2_r_ena), 64'(e2));
         if (push)
            sb.push_back(x);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog expired");
   end
   initial begin
      bus.in_valid  = 1'b1;
      bus.in_inst   = 32'h0051_0093;
      bus.in_pc     = '0;
      bus.rs1_data  = '0;
      bus.rs2_data  = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_rs1_r_ena", 64'(bus.rs1_r_ena), 64'd0);
      check("rst_out_pc", bus.out_pc, 64'd0);
      check("rst_out_imm", bus.out_imm, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      // addi x1,x2,5 / sd x3,-8(x2) / jal x1,+16
      present(32'h0051_0093, 64'h100, 64'h10, 64'h0);
      accept("addi", 1, 0, 1, mk(64'h100, TI, 5'h04, 3'd0, 7'h00, 1, 5'd1, 64'd5, 64'h10, 64'd5, 0));
      present(32'hFE31_3C23, 64'h104, 64'h100, 64'h1234);
      accept("sd", 1, 1, 1, mk(64'h104, TS, 5'h08, 3'd3, 7'h7F, 0, 5'd24, 64'hFFFF_FFFF_FFFF_FFF8,
                               64'h100, 64'h1234, 0));
      present(32'h0100_00EF, 64'h8000_0000, 64'h0, 64'h0);
      accept("jal", 0, 0, 1, mk(64'h8000_0000, TJ, 5'h1B, 3'd0, 7'h00, 1, 5'd1, 64'd16,
                                64'h8000_0000, 64'd4, 0));
      repeat (3) @(posedge clk);
      #1 bus.out_ready = 1'b0;
      // Stall: lui, addi x3,x0,-1 accepted, auipc x7,1 blocked until EX drains.
      present(32'h1234_52B7, 64'h1000, 64'h0, 64'h0);
      accept("lui", 0, 0, 1, mk(64'h1000, TU, 5'h0D, 3'd5, 7'h09, 1, 5'd5, 64'h1234_5000, 64'd0,
                                64'h1234_5000, 0));
      present(32'hFFF0_0193, 64'h1004, 64'h55, 64'h0);
      accept("addim1", 1, 0, 1, mk(64'h1004, TI, 5'h04, 3'd0, 7'h7F, 1, 5'd3, '1, 64'h55, '1, 0));
      present(32'h0000_1397, 64'h2000, 64'h0, 64'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         check("stall_out_valid", 64'(bus.out_valid), 64'd1);
         check("stall_out_pc", bus.out_pc, 64'h1000);
         check("stall_out_imm", bus.out_imm, 64'h1234_5000);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      accept("auipc", 0, 0, 1, mk(64'h2000, TU, 5'h05, 3'd1, 7'h00, 1, 5'd7, 64'h1000, 64'h2000,
                                  64'h1000, 0));
      repeat (4) @(posedge clk);
      #1 bus.out_ready = 1'b0;
      // Flush with buffer full and a third instruction presented: none may appear.
      present(32'h0051_0093, 64'h500, 64'h1, 64'h2);
      accept("flush_a", 1, 0, 0, '0);
      present(32'hFE31_3C23, 64'h504, 64'h1, 64'h2);
      accept("flush_b", 1, 1, 0, '0);
      present(32'h0100_00EF, 64'h508, 64'h0, 64'h0);
      flush = 1'b1;
      @(negedge clk);
      check("flush_pre_in_ready", 64'(bus.in_ready), 64'd0);
      check("flush_pre_out_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      present(32'h0051_0093, 64'h300, 64'h10, 64'h0);
      accept("post_flush", 1, 0, 1, mk(64'h300, TI, 5'h04, 3'd0, 7'h00, 1, 5'd1, 64'd5, 64'h10, 64'd5, 0));
      // Unknown opcode 0x7F with rd = 1.
      present(32'h0000_00FF, 64'h400, 64'h77, 64'h88);
      accept("illegal", 0, 0, 1, mk(64'h400, TN, 5'h1F, 3'd0, 7'h00, 0, 5'd1, 64'd0, 64'd0, 64'd0, ILL));
      repeat (3) @(posedge clk);
      #1 bus.out_ready = 1'b0;
      // Asynchronous reset mid-stream.
      present(32'h1234_52B7, 64'h600, 64'h0, 64'h0);
      accept("rst_lui", 0, 0, 0, '0);
      present(32'h0051_0093, 64'h604, 64'h10, 64'h0);
      @(negedge clk);
      check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("async_rst_out_pc", bus.out_pc, 64'd0);
      check("async_rst_out_imm", bus.out_imm, 64'd0);
      check("async_rst_out_op2", bus.out_op2, 64'd0);
      check("async_rst_rd_w_ena", 64'(bus.out_rd_w_ena), 64'd0);
      check("async_rst_rs1_r_ena", 64'(bus.rs1_r_ena), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, handshaked successor to the combinational decode stage; sits between IF and EX.
- Accepts one 32-bit RV64I instruction plus PC per valid/ready transfer.
- Drives regfile read ports combinationally and produces full immediate and operand decode for every instruction type.
- Holds results in a 2-entry skid buffer, so a stalled EX never drops an instruction and in_ready is a pure register output.

Parameters:
- XLEN, 64, datapath/operand/PC width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  kill all buffered entries (branch/trap redirect)
- in_valid  in  1  IF presents instruction
- in_ready  out  1  stage can accept; registered
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rs1_r_ena  out  1  regfile read enable, port 1
- rs1_r_addr  out  REG_AW  inst[19:15]
- rs2_r_ena  out  1  regfile read enable, port 2
- rs2_r_addr  out  REG_AW  inst[24:20]
- rs1_data  in  XLEN  regfile data, same cycle
- rs2_data  in  XLEN  regfile data, same cycle
- out_valid  out  1  decoded entry available
- out_ready  in  1  EX accepts
- out_pc  out  XLEN  PC of entry
- out_inst_type  out  3  `INST_*_TYPE code from defines.v
- out_opcode  out  5  inst[6:2]
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_rd_w_ena  out  1  writeback enable
- out_rd_w_addr  out  REG_AW  inst[11:7]
- out_imm  out  XLEN  sign-extended immediate
- out_op1  out  XLEN  operand 1
- out_op2  out  XLEN  operand 2
- out_illegal  out  1  unknown opcode (optional feature)

Behaviour:
- Reset, async: all out_* = 0, out_valid = 0, in_ready = 1, both buffer slots empty.
- Type decode uses the codebase opcode map.
  - LUI/AUIPC: U.
  - JAL: J.
  - JALR/LOAD/OP-IMM/OP-IMM-32/FENCE/SYSTEM: I.
  - BRANCH: B.
  - STORE: S.
  - OP/OP-32: R.
  - Others: type 0.
- Immediates, all sign-extended from inst[31] to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R and type 0: 0.
- rs1_r_ena = in_valid & type in {R, I, S, B}.
- rs2_r_ena = in_valid & type in {R, S, B}.
- Both read enables are 0 during reset.
- rd_w_ena = type in {R, I, U, J}, excluding FENCE and SYSTEM, and rd != 0.
- Operand selection:
  - op1: rs1_data for R/I/S/B; 0 for LUI; pc for AUIPC and J.
  - op2: rs2_data for R/S/B; imm for I/U; 4 for J.
- Latency: decoded entry appears on out_* the cycle after the in_valid & in_ready transfer.
- Buffer has two slots: main drives out_*, skid is overflow. States:
  - EMPTY: transfer → ONE.
  - ONE: transfer & !(out_ready) → TWO (new entry into skid). Transfer & out_ready → ONE (main replaced). out_ready & no transfer → EMPTY.
  - TWO: out_ready → ONE (skid moves to main). in_ready = 0.
- in_ready = (state != TWO), registered.
- Simultaneous transfer and pop in ONE must not bubble.
- flush has priority over everything:
  - Next cycle: EMPTY, out_valid = 0, in_ready = 1.
  - Input presented in the flush cycle is discarded.
- Reset asserted mid-operation clears state immediately, asynchronously.
- out_* hold their value while out_valid & !out_ready.

Optional Feature:
- Macro: ID_ILLEGAL_CHECK_EN.
- Defined:
  - Type-0 opcodes set out_illegal = 1 with the entry.
  - Such entries force rd_w_ena = 0, op1 = op2 = imm = 0.
  - They still flow through the handshake.
- Undefined:
  - out_illegal tied 0.
  - Type-0 opcodes decode as bubbles with rd_w_ena = 0, otherwise identical.

Test Plan:
- addi x1,x2,5 (0x00510093), rs1_data = 0x10, out_ready = 1 → next cycle out_valid = 1, type I, rd_w_ena = 1, rd = 1, imm = 5, op1 = 0x10, op2 = 5; rs1_r_ena = 1, rs2_r_ena = 0 in accept cycle.
- sd x3,-8(x2) (0xFE313C23) → type S, imm = 0xFFFF_FFFF_FFFF_FFF8, rd_w_ena = 0, rs2_r_ena = 1, op2 = rs2_data.
- jal x1,+16 (0x010000EF), pc = 0x8000_0000 → type J, imm = 16, op1 = 0x8000_0000, op2 = 4, rd_w_ena = 1.
- lui x5,0x12345 (0x123452B7); out_ready = 0 for 3 cycles while 3 instructions offered → two accepted, in_ready = 0 after second; out_* stable; on out_ready both drain in order, no loss, no duplication.
- flush asserted with buffer in TWO and in_valid = 1 → next cycle out_valid = 0, in_ready = 1, flushed and presented instructions never appear.
- Opcode 0x7F: with ID_ILLEGAL_CHECK_EN → out_illegal = 1, rd_w_ena = 0. Without it → out_illegal = 0, rd_w_ena = 0. rst pulse mid-stream → all outputs 0 asynchronously.
